instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: clear  input  1  synchronous soft restart (addr, flags, FSM).
REQ-004 SHALL have port: in_valid  input  1  instruction request valid.
REQ-005 SHALL have port: in_ready  output  1  encoder can accept a request.
REQ-006 SHALL have port: op_sel  input  3  0=ADD, 1=SUB, 2=LOAD, 3=STORE, 4=HLT, 5-7 illegal.
REQ-007 SHALL have port: rd  input  2  destination register (ADD/SUB/LOAD), source register (STORE).
REQ-008 SHALL have port: rs  input  2  source register (ADD/SUB only).
REQ-009 SHALL have port: imm  input  8  address byte (LOAD/STORE only).
REQ-010 SHALL have port: byte_valid  output  1  output byte valid.
REQ-011 SHALL have port: byte_ready  input  1  sink (instruction memory writer) accepts byte.
REQ-012 SHALL have port: byte_data  output  8  encoded instruction byte.
REQ-013 SHALL have port: byte_addr  output  8  instruction-memory address of byte_data.
REQ-014 SHALL have port: err  output  1  one-cycle pulse on illegal op_sel accept.
REQ-015 SHALL have port: done  output  1  high after HLT byte accepted, until clear/reset.
REQ-016 SHALL have port: addr_wrap  output  1  sticky; set when byte_addr wraps 255->0.

Function
REQ-017 SHALL encode ADD as {0001,rd,rs}, SUB as {0010,rd,rs}, one byte each.
REQ-018 SHALL encode LOAD as {1001,rd,00} then imm; STORE as {1101,rd,00} then imm.
REQ-019 SHALL encode HLT as 8'hF0, one byte.
REQ-020 SHALL use FSM states IDLE, BYTE0, BYTE1, HALTED.
REQ-021 SHALL drive in_ready=1 only in IDLE; handshake = in_valid && in_ready.
REQ-022 SHALL register rd, rs, imm and op_sel on handshake; later input changes have no effect.
REQ-023 SHALL go IDLE->BYTE0 on legal handshake; byte_valid=1 in the next cycle (latency 1).
REQ-024 SHALL on illegal op_sel handshake pulse err next cycle, stay IDLE, emit no byte, keep byte_addr unchanged.
REQ-025 SHALL hold byte_data and byte_addr stable while byte_valid && !byte_ready.
REQ-026 SHALL increment byte_addr by 1 (mod 256) on each byte handshake (byte_valid && byte_ready).
REQ-027 SHALL on BYTE0 handshake go to BYTE1 (LOAD/STORE), HALTED (HLT), else IDLE.
REQ-028 SHALL on BYTE1 handshake return to IDLE.
REQ-029 SHALL set done and enter HALTED on HLT byte handshake; HALTED holds in_ready=0, byte_valid=0.
REQ-030 SHALL set addr_wrap when a byte handshake occurs at byte_addr=255; byte_addr becomes 0.
REQ-031 SHALL give clear priority over all handshakes: next cycle state IDLE, byte_addr=0, done=0, addr_wrap=0, err=0; a partially emitted instruction is abandoned.
REQ-032 SHALL drive byte_valid=0 in IDLE and HALTED; byte_data is don't-care when byte_valid=0 but SHALL be 8'h00.
REQ-033 SHALL sustain one byte per cycle within an instruction under continuous byte_ready; one idle cycle (IDLE) between instructions.

Reset
REQ-034 SHALL on rst_n=0 immediately force state IDLE, byte_addr=0, byte_valid=0, byte_data=0, err=0, done=0, addr_wrap=0, registered fields=0.
REQ-035 SHALL, with rst_n low, hold in_ready=0; in_ready rises in the first cycle after rst_n deassertion.
REQ-036 SHALL abandon any in-flight instruction on reset mid-operation with no partial byte reissued.

Structure
REQ-037 SHALL take opcode nibble constants (ADD, SUB, LOAD, STORE, HLT) and op_sel codes from shared package cpu_pkg, the same values the decode side uses.
REQ-038 SHALL place byte formation in combinational sub-module instr_pack (op_sel, rd, rs, imm, byte index -> byte_data); FSM and counters stay in instr_encoder.

Verification
REQ-039 SHALL cover: ADD rd=2 rs=1, byte_ready=1 -> byte 8'h19 at addr 0, next instr addr 1.
REQ-040 SHALL cover: LOAD rd=3 imm=8'h42 -> 8'h9C then 8'h42 on consecutive cycles, addrs 0,1.
REQ-041 SHALL cover: STORE rd=1 imm=8'h80 with byte_ready low 3 cycles -> 8'hD4 held stable 4 cycles, then 8'h80.
REQ-042 SHALL cover: HLT -> 8'hF0, done=1, in_ready=0 until clear pulse; then byte_addr=0, in_ready=1.
REQ-043 SHALL cover: op_sel=6 -> err pulse one cycle, no byte_valid, byte_addr unchanged.
REQ-044 SHALL cover: 256 ADDs then one more -> addr_wrap=1, 257th byte at addr 0; rst_n low during BYTE1 of a LOAD -> byte_valid=0 immediately, addr=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU encoding constants: op_sel codes, opcode nibbles,
// encoder FSM states. Decode side imports the same package.
package cpu_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_STORE = 3'd3;
  localparam logic [2:0] OP_HLT   = 3'd4;

  localparam logic [3:0] NIB_ADD   = 4'h1;
  localparam logic [3:0] NIB_SUB   = 4'h2;
  localparam logic [3:0] NIB_LOAD  = 4'h9;
  localparam logic [3:0] NIB_STORE = 4'hD;
  localparam logic [3:0] NIB_HLT   = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    BYTE0,
    BYTE1,
    HALTED
  } enc_state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_HLT;
  endfunction

  function automatic logic op_two_byte(input logic [2:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and byte-stream handshake bundle of the instruction encoder.
// master = requester/sink side, slave = encoder.
interface instr_encoder_if;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op_sel;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [7:0] imm;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_data;
  logic [7:0] byte_addr;
  logic       err;
  logic       done;
  logic       addr_wrap;

  modport master (
    output clear, in_valid, op_sel, rd, rs, imm,
    output byte_ready,
    input  in_ready, byte_valid, byte_data,
    input  byte_addr, err, done, addr_wrap
  );

  modport slave (
    input  clear, in_valid, op_sel, rd, rs, imm,
    input  byte_ready,
    output in_ready, byte_valid, byte_data,
    output byte_addr, err, done, addr_wrap
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational byte former: latched instruction fields plus
// byte index -> instruction-memory byte.
module instr_pack
  import cpu_pkg::*;
(
  input  logic [2:0] op_i,
  input  logic [1:0] rd_i,
  input  logic [1:0] rs_i,
  input  logic [7:0] imm_i,
  input  logic       idx_i,
  output logic [7:0] data_o
);

  always_comb begin
    data_o = 8'h00;
    unique case (1'b1)
      idx_i:
        data_o = imm_i;
      !idx_i && (op_i == OP_ADD):
        data_o = {NIB_ADD, rd_i, rs_i};
      !idx_i && (op_i == OP_SUB):
        data_o = {NIB_SUB, rd_i, rs_i};
      !idx_i && (op_i == OP_LOAD):
        data_o = {NIB_LOAD, rd_i, 2'b00};
      !idx_i && (op_i == OP_STORE):
        data_o = {NIB_STORE, rd_i, 2'b00};
      !idx_i && (op_i == OP_HLT):
        data_o = {NIB_HLT, 4'h0};
      default:
        data_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts one instruction request at a time and
// streams its 1-2 encoded bytes with addresses to instruction memory.
module instr_encoder
  import cpu_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  instr_encoder_if.slave bus
);

  enc_state_e state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [1:0] rd_q, rd_d;
  logic [1:0] rs_q, rs_d;
  logic [7:0] imm_q, imm_d;
  logic [7:0] addr_q, addr_d;
  logic       rdy_q, rdy_d;
  logic       vld_q, vld_d;
  logic       err_q, err_d;
  logic       done_q, done_d;
  logic       wrap_q, wrap_d;
  logic       hs_in;
  logic       hs_byte;
  logic [7:0] pack_byte;

  instr_pack u_pack (
    .op_i   (op_q),
    .rd_i   (rd_q),
    .rs_i   (rs_q),
    .imm_i  (imm_q),
    .idx_i  (state_q == BYTE1),
    .data_o (pack_byte)
  );

  assign hs_in   = bus.in_valid && rdy_q;
  assign hs_byte = vld_q && bus.byte_ready;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    imm_d   = imm_q;
    addr_d  = addr_q;
    err_d   = 1'b0;
    done_d  = done_q;
    wrap_d  = wrap_q;
    if (bus.clear) begin
      state_d = IDLE;
      addr_d  = 8'h00;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
    end else begin
      if (hs_byte) begin
        addr_d = addr_q + 8'd1;
        if (addr_q == 8'hFF) wrap_d = 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (hs_in) begin
            op_d  = bus.op_sel;
            rd_d  = bus.rd;
            rs_d  = bus.rs;
            imm_d = bus.imm;
            if (op_legal(bus.op_sel)) state_d = BYTE0;
            else                      err_d   = 1'b1;
          end
        end
        BYTE0: begin
          if (hs_byte) begin
            unique case (1'b1)
              op_two_byte(op_q): state_d = BYTE1;
              op_q == OP_HLT: begin
                state_d = HALTED;
                done_d  = 1'b1;
              end
              default: state_d = IDLE;
            endcase
          end
        end
        BYTE1: begin
          if (hs_byte) state_d = IDLE;
        end
        HALTED: state_d = HALTED;
      endcase
    end
    // handshake flags are registered so they stay low through reset
    rdy_d = (state_d == IDLE);
    vld_d = (state_d == BYTE0) || (state_d == BYTE1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      rd_q    <= 2'd0;
      rs_q    <= 2'd0;
      imm_q   <= 8'h00;
      addr_q  <= 8'h00;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      imm_q   <= imm_d;
      addr_q  <= addr_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.in_ready   = rdy_q;
  assign bus.byte_valid = vld_q;
  assign bus.byte_data  = vld_q ? pack_byte : 8'h00;
  assign bus.byte_addr  = addr_q;
  assign bus.err        = err_q;
  assign bus.done       = done_q;
  assign bus.addr_wrap  = wrap_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder against a byte-stream
// reference model (encoded bytes, address counter, sticky flags).
module tb_instr_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_addr = 0;
  bit exp_wrap = 1'b0;
  bit exp_done = 1'b0;

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int enc_len(input int op);
    if (op == 2 || op == 3) return 2;
    if (op >= 0 && op <= 4) return 1;
    return 0;
  endfunction

  function automatic int enc_byte(input int op, input int rd,
                                  input int rs, input int imm,
                                  input int idx);
    if (idx == 1) return imm;
    case (op)
      0: return 16 + 4 * rd + rs;
      1: return 32 + 4 * rd + rs;
      2: return 144 + 4 * rd;
      3: return 208 + 4 * rd;
      4: return 240;
      default: return 0;
    endcase
  endfunction

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    exp_addr = 0;
    exp_wrap = 1'b0;
    exp_done = 1'b0;
    checks++;
    if ({bus.byte_addr, bus.done, bus.addr_wrap, bus.err,
         bus.byte_valid, bus.in_ready} !== {8'h00, 5'b00001}) begin
      errors++;
      $display("FAIL clear: addr=%h done=%b wrap=%b err=%b vld=%b rdy=%b required 00,0,0,0,0,1",
               bus.byte_addr, bus.done, bus.addr_wrap, bus.err,
               bus.byte_valid, bus.in_ready);
    end
  endtask

  task automatic send_instr(input int op, input int rd,
                            input int rs, input int imm,
                            input int stall);
    int n;
    int st;
    int guard;
    logic [7:0] eb;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_wait: in_ready=%b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.op_sel = 3'(op);
    bus.rd = 2'(rd);
    bus.rs = 2'(rs);
    bus.imm = 8'(imm);
    tick();
    bus.in_valid = 1'b0;
    bus.op_sel = 3'($urandom);
    bus.rd = 2'($urandom);
    bus.rs = 2'($urandom);
    bus.imm = 8'($urandom);
    n = enc_len(op);
    if (n == 0) begin
      checks++;
      if ({bus.err, bus.byte_valid, bus.byte_addr} !==
          {2'b10, 8'(exp_addr)}) begin
        errors++;
        $display("FAIL illegal_op%0d: err=%b vld=%b addr=%h required 1,0,%h",
                 op, bus.err, bus.byte_valid, bus.byte_addr, 8'(exp_addr));
      end
      tick();
      checks++;
      if ({bus.err, bus.in_ready, bus.byte_valid} !== 3'b010) begin
        errors++;
        $display("FAIL err_pulse: err=%b rdy=%b vld=%b required 0,1,0",
                 bus.err, bus.in_ready, bus.byte_valid);
      end
      return;
    end
    for (int i = 0; i < n; i++) begin
      st = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      eb = 8'(enc_byte(op, rd, rs, imm, i));
      for (int s = 0; s <= st; s++) begin
        bus.byte_ready = (s == st);
        checks++;
        if ({bus.byte_valid, bus.byte_data, bus.byte_addr} !==
            {1'b1, eb, 8'(exp_addr)}) begin
          errors++;
          $display("FAIL byte%0d_op%0d: vld=%b data=%h addr=%h required 1,%h,%h",
                   i, op, bus.byte_valid, bus.byte_data,
                   bus.byte_addr, eb, 8'(exp_addr));
        end
        tick();
      end
      bus.byte_ready = 1'b0;
      if (exp_addr == 255) exp_wrap = 1'b1;
      exp_addr = (exp_addr + 1) % 256;
      checks++;
      if (bus.addr_wrap !== exp_wrap) begin
        errors++;
        $display("FAIL addr_wrap: wrap=%b required %b",
                 bus.addr_wrap, exp_wrap);
      end
    end
    if (op == 4) exp_done = 1'b1;
    checks++;
    if ({bus.done, bus.in_ready, bus.byte_valid, bus.byte_data} !==
        {exp_done, !exp_done, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL after_op%0d: done=%b rdy=%b vld=%b data=%h required %b,%b,0,00",
               op, bus.done, bus.in_ready, bus.byte_valid,
               bus.byte_data, exp_done, !exp_done);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.byte_valid, bus.byte_data, bus.byte_addr,
         bus.err, bus.done, bus.addr_wrap} !== 21'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b data=%h addr=%h err=%b done=%b wrap=%b required all 0",
               bus.in_ready, bus.byte_valid, bus.byte_data,
               bus.byte_addr, bus.err, bus.done, bus.addr_wrap);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_rdy: in_ready=%b required 0", bus.in_ready);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rdy: in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    send_instr(0, 2, 1, 0, 0);
    send_instr(0, 3, 0, 0, 0);
    send_instr(1, 1, 2, 0, 1);
  endtask

  task automatic test_load();
    do_clear();
    send_instr(2, 3, 0, 8'h42, 0);
  endtask

  task automatic test_store();
    do_clear();
    send_instr(3, 1, 0, 8'h80, 3);
  endtask

  task automatic test_illegal();
    send_instr(0, 1, 1, 0, 0);
    send_instr(6, 2, 2, 8'h55, 0);
    send_instr(5, 0, 0, 0, 0);
    send_instr(7, 3, 3, 8'hFF, 0);
    send_instr(1, 0, 3, 0, 0);
  endtask

  task automatic test_hlt();
    send_instr(4, 0, 0, 0, 1);
    bus.in_valid = 1'b1;
    bus.op_sel = 3'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.done, bus.in_ready, bus.byte_valid} !== 3'b100) begin
        errors++;
        $display("FAIL halted_hold: done=%b rdy=%b vld=%b required 1,0,0",
                 bus.done, bus.in_ready, bus.byte_valid);
      end
    end
    bus.in_valid = 1'b0;
    do_clear();
    send_instr(0, 1, 3, 0, 0);
  endtask

  task automatic test_clear_mid();
    bus.in_valid = 1'b1;
    bus.op_sel = 3'd3;
    bus.rd = 2'd2;
    tick();
    bus.in_valid = 1'b0;
    bus.byte_ready = 1'b1;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.byte_ready = 1'b0;
    exp_addr = 0;
    exp_wrap = 1'b0;
    exp_done = 1'b0;
    checks++;
    if ({bus.byte_valid, bus.byte_addr, bus.in_ready} !== {1'b0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL clear_mid: vld=%b addr=%h rdy=%b required 0,00,1",
               bus.byte_valid, bus.byte_addr, bus.in_ready);
    end
  endtask

  task automatic test_random();
    int op;
    for (int k = 0; k < 60; k++) begin
      op = int'($urandom_range(0, 7));
      send_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 255)), -1);
      if (op == 4) do_clear();
    end
  endtask

  task automatic test_wrap();
    do_clear();
    for (int k = 0; k < 256; k++)
      send_instr(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, 0);
    checks++;
    if ({bus.addr_wrap, bus.byte_addr} !== {1'b1, 8'h00}) begin
      errors++;
      $display("FAIL wrap_256: wrap=%b addr=%h required 1,00",
               bus.addr_wrap, bus.byte_addr);
    end
    send_instr(1, 2, 2, 0, 0);
  endtask

  task automatic test_reset_mid();
    do_clear();
    bus.in_valid = 1'b1;
    bus.op_sel = 3'd2;
    bus.rd = 2'd3;
    bus.imm = 8'h42;
    tick();
    bus.in_valid = 1'b0;
    bus.byte_ready = 1'b1;
    tick();
    bus.byte_ready = 1'b0;
    checks++;
    if ({bus.byte_valid, bus.byte_data, bus.byte_addr} !== {1'b1, 8'h42, 8'h01}) begin
      errors++;
      $display("FAIL load_byte1: vld=%b data=%h addr=%h required 1,42,01",
               bus.byte_valid, bus.byte_data, bus.byte_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.byte_valid, bus.byte_data, bus.byte_addr, bus.in_ready} !== 18'd0) begin
      errors++;
      $display("FAIL reset_mid: vld=%b data=%h addr=%h rdy=%b required 0,00,00,0",
               bus.byte_valid, bus.byte_data, bus.byte_addr, bus.in_ready);
    end
    tick();
    rst_n = 1'b1;
    exp_addr = 0;
    exp_wrap = 1'b0;
    exp_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({bus.byte_valid, bus.in_ready, bus.byte_addr} !== {2'b01, 8'h00}) begin
        errors++;
        $display("FAIL reset_mid_after: vld=%b rdy=%b addr=%h required 0,1,00",
                 bus.byte_valid, bus.in_ready, bus.byte_addr);
      end
    end
    send_instr(0, 2, 1, 0, 0);
  endtask

  initial begin
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.op_sel = 3'd0;
    bus.rd = 2'd0;
    bus.rs = 2'd0;
    bus.imm = 8'h00;
    bus.byte_ready = 1'b0;
    test_reset();
    test_add();
    test_load();
    test_store();
    test_illegal();
    test_hlt();
    test_clear_mid();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
